// File: rtl/powlib_tdpram.sv
// rtl/powlib_tdpram.sv - true dual-port RAM with byte enables, 1..3 cycle read latency and read-valid strobes
//
// Optional feature macro: POWLIB_TDPRAM_COLLCHK_EN
//   defined   : coll pulses for one cycle after both ports write overlapping bytes of the same index,
//               and a simulation warning reports the time and index.
//   undefined : coll is tied low and no compare logic exists.
//
// Ports (port B mirrors port A with the b prefix):
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset (memory contents are kept)
//   aidx     in   IW     word index
//   awrdata  in   W      write data
//   awrvld   in   1      write strobe
//   awrbe    in   W/8    byte enables, honoured only when EWBE=1
//   ardvld   in   1      read request
//   ardata   out  W      read data, holds the last delivered word
//   ardvldo  out  1      one-cycle read-data valid, LAT cycles after the request
//   coll     out  1      same-index overlapping write collision pulse
module powlib_tdpram #(
  parameter int W = 32,
  parameter int D = 8,
  parameter logic [W*D-1:0] INIT = '0,
  parameter int EWBE = 0,
  parameter int LAT = 1,
  parameter int WRMODE = 0,
  localparam int IW = (D > 1) ? $clog2(D) : 1,
  localparam int NB = (W >= 8) ? W / 8 : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] aidx,
  input  logic [W-1:0]  awrdata,
  input  logic          awrvld,
  input  logic [NB-1:0] awrbe,
  input  logic          ardvld,
  output logic [W-1:0]  ardata,
  output logic          ardvldo,
  input  logic [IW-1:0] bidx,
  input  logic [W-1:0]  bwrdata,
  input  logic          bwrvld,
  input  logic [NB-1:0] bwrbe,
  input  logic          brdvld,
  output logic [W-1:0]  brdata,
  output logic          brdvldo,
  output logic          coll
);

  localparam int L = (LAT >= 1 && LAT <= 3) ? LAT : 1;

  if (LAT < 1 || LAT > 3) begin : g_bad_lat
    $fatal(1, "powlib_tdpram: LAT must be in 1..3");
  end

  // Storage starts from the INIT image; reset deliberately leaves it alone.
  logic [D-1:0][W-1:0] mem = INIT;

  function automatic logic [W-1:0] bit_mask(input logic [NB-1:0] be);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      m[i] = (EWBE == 0) ? 1'b1 : be[i/8];
    end
    return m;
  endfunction

  logic a_ok, b_ok;

  // Only a non-power-of-two depth can see indices past the end of the array.
  if ((1 << IW) == D) begin : g_pow2
    assign a_ok = 1'b1;
    assign b_ok = 1'b1;
  end else begin : g_range
    assign a_ok = 32'(aidx) < 32'(D);
    assign b_ok = 32'(bidx) < 32'(D);
  end

  logic          same;
  logic [W-1:0]  a_mask, b_mask, a_old, b_old, a_new, b_new, ab_new, a_rword, b_rword;

  always_comb begin
    a_mask = bit_mask(awrbe);
    b_mask = bit_mask(bwrbe);
    a_old  = a_ok ? mem[aidx] : '0;
    b_old  = b_ok ? mem[bidx] : '0;
    a_new  = (a_old & ~a_mask) | (awrdata & a_mask);
    b_new  = (b_old & ~b_mask) | (bwrdata & b_mask);
    same   = (aidx == bidx);
    // Both ports on one word: A owns every byte it enables, B fills only the bytes A leaves alone.
    ab_new = (a_old & ~(a_mask | b_mask)) | (awrdata & a_mask) | (bwrdata & b_mask & ~a_mask);
    // A port only ever sees its own write (write-first); the other port's write is never visible
    // to a read in the same cycle.
    a_rword = !a_ok ? '0 : ((WRMODE != 0 && awrvld) ? a_new : a_old);
    b_rword = !b_ok ? '0 : ((WRMODE != 0 && bwrvld) ? b_new : b_old);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (awrvld && bwrvld && same) begin
        if (a_ok) mem[aidx] <= ab_new;
      end else begin
        if (awrvld && a_ok) mem[aidx] <= a_new;
        if (bwrvld && b_ok) mem[bidx] <= b_new;
      end
    end
  end

  // Stage 0 is the array read register; later stages only load when the stage before is valid,
  // so the last stage naturally holds the most recently delivered word.
  logic [L-1:0]        a_vld, b_vld;
  logic [L-1:0][W-1:0] a_dat, b_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld <= '0;
      b_vld <= '0;
      a_dat <= '0;
      b_dat <= '0;
    end else begin
      a_vld[0] <= ardvld;
      b_vld[0] <= brdvld;
      if (ardvld) a_dat[0] <= a_rword;
      if (brdvld) b_dat[0] <= b_rword;
      for (int i = 1; i < L; i++) begin
        a_vld[i] <= a_vld[i-1];
        b_vld[i] <= b_vld[i-1];
        if (a_vld[i-1]) a_dat[i] <= a_dat[i-1];
        if (b_vld[i-1]) b_dat[i] <= b_dat[i-1];
      end
    end
  end

  assign ardata  = a_dat[L-1];
  assign ardvldo = a_vld[L-1];
  assign brdata  = b_dat[L-1];
  assign brdvldo = b_vld[L-1];

`ifdef POWLIB_TDPRAM_COLLCHK_EN
  logic coll_q;
  logic coll_hit;

  assign coll_hit = awrvld && bwrvld && same && (|(a_mask & b_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_hit;
      if (coll_hit) $warning("powlib_tdpram: write collision at %0t on index %0d", $time, aidx);
    end
  end

  assign coll = coll_q;
`else
  assign coll = 1'b0;
`endif

endmodule

// File: tb/tb_powlib_tdpram.sv
// tb/tb_powlib_tdpram.sv - self-checking bench for powlib_tdpram across three configurations
module tb_powlib_tdpram;

  localparam int ND = 3;
  localparam logic [8*32-1:0] INIT8 = {32'h0, 32'h0, 32'h0, 32'h0,
                                       32'h0FED, 32'hCBA9, 32'h5678, 32'h1234};
  localparam logic [6*32-1:0] INIT6 = INIT8[6*32-1:0];

  // d0: D=8 EWBE=1 LAT=1 read-first, d1: D=6 EWBE=0 LAT=2 write-first, d2: D=8 EWBE=1 LAT=3 write-first
  localparam int CFG_D    [ND] = '{8, 6, 8};
  localparam int CFG_EWBE [ND] = '{1, 0, 1};
  localparam int CFG_LAT  [ND] = '{1, 2, 3};
  localparam int CFG_WRM  [ND] = '{0, 1, 1};

`ifdef POWLIB_TDPRAM_COLLCHK_EN
  localparam bit COLL_ON = 1'b1;
`else
  localparam bit COLL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  aidx, bidx;
  logic [31:0] awrdata, bwrdata;
  logic        awrvld, bwrvld, ardvld, brdvld;
  logic [3:0]  awrbe, bwrbe;
  logic [31:0] ardata [ND];
  logic [31:0] brdata [ND];
  logic        ardvldo [ND];
  logic        brdvldo [ND];
  logic        coll [ND];

  always #5 clk = ~clk;

  powlib_tdpram #(.W(32), .D(8), .INIT(INIT8), .EWBE(1), .LAT(1), .WRMODE(0)) d0 (
    .clk(clk), .rst(rst),
    .aidx(aidx), .awrdata(awrdata), .awrvld(awrvld), .awrbe(awrbe), .ardvld(ardvld),
    .ardata(ardata[0]), .ardvldo(ardvldo[0]),
    .bidx(bidx), .bwrdata(bwrdata), .bwrvld(bwrvld), .bwrbe(bwrbe), .brdvld(brdvld),
    .brdata(brdata[0]), .brdvldo(brdvldo[0]), .coll(coll[0]));

  powlib_tdpram #(.W(32), .D(6), .INIT(INIT6), .EWBE(0), .LAT(2), .WRMODE(1)) d1 (
    .clk(clk), .rst(rst),
    .aidx(aidx), .awrdata(awrdata), .awrvld(awrvld), .awrbe(awrbe), .ardvld(ardvld),
    .ardata(ardata[1]), .ardvldo(ardvldo[1]),
    .bidx(bidx), .bwrdata(bwrdata), .bwrvld(bwrvld), .bwrbe(bwrbe), .brdvld(brdvld),
    .brdata(brdata[1]), .brdvldo(brdvldo[1]), .coll(coll[1]));

  powlib_tdpram #(.W(32), .D(8), .INIT(INIT8), .EWBE(1), .LAT(3), .WRMODE(1)) d2 (
    .clk(clk), .rst(rst),
    .aidx(aidx), .awrdata(awrdata), .awrvld(awrvld), .awrbe(awrbe), .ardvld(ardvld),
    .ardata(ardata[2]), .ardvldo(ardvldo[2]),
    .bidx(bidx), .bwrdata(bwrdata), .bwrvld(bwrvld), .bwrbe(bwrbe), .brdvld(brdvld),
    .brdata(brdata[2]), .brdvldo(brdvldo[2]), .coll(coll[2]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: word array plus a delivery calendar indexed by the sampling edge.
  logic [31:0] mm [ND][8];
  logic        cal_v [ND][2][8];
  logic [31:0] cal_d [ND][2][8];
  logic [31:0] last_d [ND][2];
  logic        exp_coll [ND];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input int n, input logic [31:0] old,
                                        input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (CFG_EWBE[n] == 0 || be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic rd_overlap(input int n);
    logic o;
    o = 1'b0;
    for (int k = 0; k < 4; k++)
      if ((CFG_EWBE[n] == 0 || awrbe[k]) && (CFG_EWBE[n] == 0 || bwrbe[k])) o = 1'b1;
    return o;
  endfunction

  function automatic logic [31:0] rd_word(input int n, input logic [2:0] idx, input logic wv,
                                          input logic [31:0] wd, input logic [3:0] be);
    if (int'(idx) >= CFG_D[n]) return 32'h0;
    if (CFG_WRM[n] != 0 && wv) return merge(n, mm[n][idx], wd, be);
    return mm[n][idx];
  endfunction

  task automatic sched(input int n, input int p, input logic [31:0] w);
    int s;
    s = (cyc + CFG_LAT[n]) % 8;
    cal_v[n][p][s] = 1'b1;
    cal_d[n][p][s] = w;
  endtask

  task automatic model_step();
    cyc++;
    for (int n = 0; n < ND; n++) begin
      if (rst) begin
        for (int s = 0; s < 8; s++) begin
          cal_v[n][0][s] = 1'b0;
          cal_v[n][1][s] = 1'b0;
        end
        last_d[n][0] = 32'h0;
        last_d[n][1] = 32'h0;
        exp_coll[n]  = 1'b0;
      end else begin
        if (ardvld) sched(n, 0, rd_word(n, aidx, awrvld, awrdata, awrbe));
        if (brdvld) sched(n, 1, rd_word(n, bidx, bwrvld, bwrdata, bwrbe));
        exp_coll[n] = COLL_ON && awrvld && bwrvld && (aidx == bidx) && rd_overlap(n);
        // B first, then A on top: A wins the bytes both enable.
        if (bwrvld && int'(bidx) < CFG_D[n]) mm[n][bidx] = merge(n, mm[n][bidx], bwrdata, bwrbe);
        if (awrvld && int'(aidx) < CFG_D[n]) mm[n][aidx] = merge(n, mm[n][aidx], awrdata, awrbe);
      end
    end
  endtask

  // Outputs seen just after edge cyc are what edge cyc+1 samples.
  task automatic model_check();
    int s;
    s = (cyc + 1) % 8;
    for (int n = 0; n < ND; n++) begin
      for (int p = 0; p < 2; p++) begin
        logic ev;
        ev = cal_v[n][p][s];
        if (ev) last_d[n][p] = cal_d[n][p][s];
        cal_v[n][p][s] = 1'b0;
        if (p == 0) begin
          chk($sformatf("model d%0d a_vld cyc%0d", n, cyc), 64'(ardvldo[n]), 64'(ev));
          chk($sformatf("model d%0d a_data cyc%0d", n, cyc), 64'(ardata[n]), 64'(last_d[n][p]));
        end else begin
          chk($sformatf("model d%0d b_vld cyc%0d", n, cyc), 64'(brdvldo[n]), 64'(ev));
          chk($sformatf("model d%0d b_data cyc%0d", n, cyc), 64'(brdata[n]), 64'(last_d[n][p]));
        end
      end
      chk($sformatf("model d%0d coll cyc%0d", n, cyc), 64'(coll[n]), 64'(exp_coll[n]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic idle();
    rst = 1'b0;
    awrvld = 1'b0; bwrvld = 1'b0; ardvld = 1'b0; brdvld = 1'b0;
    awrbe = 4'hF; bwrbe = 4'hF;
    awrdata = 32'h0; bwrdata = 32'h0;
  endtask

  typedef struct {
    logic [2:0]  aidx; logic [31:0] awrdata; logic awrvld; logic [3:0] awrbe; logic ardvld;
    logic [2:0]  bidx; logic [31:0] bwrdata; logic bwrvld; logic [3:0] bwrbe; logic brdvld;
    logic        eav;  logic [31:0] ead;     logic ebv;    logic [31:0] ebd;  logic ecoll;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Expectations for d0 (LAT=1, read-first, byte enables honoured), checked just after each edge.
    tbl[0]  = '{3'd0, 32'h0,        1'b0, 4'h0, 1'b1, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 32'h00001234, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{3'd1, 32'h0,        1'b0, 4'h0, 1'b1, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 32'h00005678, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{3'd2, 32'h0,        1'b0, 4'h0, 1'b1, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 32'h0000CBA9, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{3'd3, 32'h0,        1'b0, 4'h0, 1'b1, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 32'h00000FED, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{3'd1, 32'hAABBCCDD, 1'b1, 4'h5, 1'b0, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 32'h00000FED, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 3'd1, 32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 32'h00000FED, 1'b1, 32'h00BB56DD, 1'b0};
    tbl[6]  = '{3'd3, 32'h11111111, 1'b1, 4'hF, 1'b0, 3'd3, 32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 32'h00000FED, 1'b1, 32'h00000FED, 1'b0};
    tbl[7]  = '{3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 3'd3, 32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 32'h00000FED, 1'b1, 32'h11111111, 1'b0};
    tbl[8]  = '{3'd0, 32'hAAAAAAAA, 1'b1, 4'h3, 1'b0, 3'd0, 32'hBBBBBBBB, 1'b1, 4'hE, 1'b0, 1'b0, 32'h00000FED, 1'b0, 32'h11111111, COLL_ON};
    tbl[9]  = '{3'd0, 32'h0,        1'b0, 4'h0, 1'b1, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 32'hBBBBAAAA, 1'b0, 32'h11111111, 1'b0};
    tbl[10] = '{3'd2, 32'h22222222, 1'b1, 4'hF, 1'b1, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 32'h0000CBA9, 1'b0, 32'h11111111, 1'b0};
    tbl[11] = '{3'd2, 32'h0,        1'b0, 4'h0, 1'b1, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 32'h22222222, 1'b0, 32'h11111111, 1'b0};
    tbl[12] = '{3'd4, 32'h0,        1'b0, 4'h0, 1'b1, 3'd4, 32'h55555555, 1'b1, 4'hF, 1'b0, 1'b1, 32'h00000000, 1'b0, 32'h11111111, 1'b0};
    tbl[13] = '{3'd4, 32'h0,        1'b0, 4'h0, 1'b1, 3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b1, 32'h55555555, 1'b0, 32'h11111111, 1'b0};
    tbl[14] = '{3'd5, 32'h12345678, 1'b1, 4'h3, 1'b0, 3'd5, 32'h9ABCDEF0, 1'b1, 4'hC, 1'b0, 1'b0, 32'h55555555, 1'b0, 32'h11111111, 1'b0};
    tbl[15] = '{3'd0, 32'h0,        1'b0, 4'h0, 1'b0, 3'd5, 32'h0,        1'b0, 4'h0, 1'b1, 1'b0, 32'h55555555, 1'b1, 32'h9ABC5678, 1'b0};

    for (int n = 0; n < ND; n++)
      for (int i = 0; i < 8; i++) mm[n][i] = INIT8[i*32 +: 32];

    aidx = 3'd0; bidx = 3'd0;
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    for (int n = 0; n < ND; n++) begin
      chk($sformatf("reset d%0d ardata", n), 64'(ardata[n]), 64'h0);
      chk($sformatf("reset d%0d rdvldo", n), 64'({ardvldo[n], brdvldo[n]}), 64'h0);
      chk($sformatf("reset d%0d coll", n), 64'(coll[n]), 64'h0);
    end

    // Single read of idx2: valid appears once, LAT edges later, then data holds.
    idle(); ardvld = 1'b1; aidx = 3'd2;
    cycle();
    idle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lat3 vld k%0d", k), 64'(ardvldo[2]), 64'(k == 2));
      chk($sformatf("lat3 data k%0d", k), 64'(ardata[2]), (k >= 2) ? 64'h0000CBA9 : 64'h0);
      if (k == 0) chk("lat1 vld", 64'(ardvldo[0]), 64'h1);
      if (k == 1) chk("lat2 data", 64'(ardata[1]), 64'h0000CBA9);
      cycle();
    end

    // Reads in flight are dropped by reset; memory survives it.
    idle(); ardvld = 1'b1; aidx = 3'd0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst flush vld", 64'(ardvldo[1]), 64'h0);
    chk("rst flush data", 64'(ardata[1]), 64'h0);
    idle();
    cycle();
    chk("rst no late pulse", 64'(ardvldo[1]), 64'h0);
    chk("rst no late data", 64'(ardata[1]), 64'h0);
    ardvld = 1'b1; aidx = 3'd0;
    cycle();
    idle();
    cycle();
    chk("mem kept vld", 64'(ardvldo[1]), 64'h1);
    chk("mem kept data", 64'(ardata[1]), 64'h00001234);

    for (int r = 0; r < 16; r++) begin
      rst = 1'b0;
      aidx = tbl[r].aidx; awrdata = tbl[r].awrdata; awrvld = tbl[r].awrvld;
      awrbe = tbl[r].awrbe; ardvld = tbl[r].ardvld;
      bidx = tbl[r].bidx; bwrdata = tbl[r].bwrdata; bwrvld = tbl[r].bwrvld;
      bwrbe = tbl[r].bwrbe; brdvld = tbl[r].brdvld;
      cycle();
      chk($sformatf("tbl%0d a_vld", r), 64'(ardvldo[0]), 64'(tbl[r].eav));
      chk($sformatf("tbl%0d a_data", r), 64'(ardata[0]), 64'(tbl[r].ead));
      chk($sformatf("tbl%0d b_vld", r), 64'(brdvldo[0]), 64'(tbl[r].ebv));
      chk($sformatf("tbl%0d b_data", r), 64'(brdata[0]), 64'(tbl[r].ebd));
      chk($sformatf("tbl%0d coll", r), 64'(coll[0]), 64'(tbl[r].ecoll));
    end

    // Same-port read+write: read-first d0 sees old word, write-first d2 sees new word.
    idle(); aidx = 3'd3; awrdata = 32'h33333333; awrvld = 1'b1; ardvld = 1'b1;
    cycle();
    idle();
    chk("rdfirst data", 64'(ardata[0]), 64'h11111111);
    cycle();
    cycle();
    chk("wrfirst vld", 64'(ardvldo[2]), 64'h1);
    chk("wrfirst data", 64'(ardata[2]), 64'h33333333);

    // Index past the end of the D=6 instance: write dropped, read gives 0 with normal timing.
    idle(); bidx = 3'd7; bwrdata = 32'hFFFFFFFF; bwrvld = 1'b1;
    cycle();
    idle(); aidx = 3'd7; ardvld = 1'b1;
    cycle();
    idle();
    chk("oor d0 data", 64'(ardata[0]), 64'hFFFFFFFF);
    cycle();
    chk("oor d1 vld", 64'(ardvldo[1]), 64'h1);
    chk("oor d1 data", 64'(ardata[1]), 64'h0);

    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      aidx    = 3'($urandom_range(0, 7));
      bidx    = ($urandom_range(0, 3) == 0) ? aidx : 3'($urandom_range(0, 7));
      awrdata = $urandom;
      bwrdata = $urandom;
      awrvld  = $urandom_range(0, 1) == 1;
      bwrvld  = $urandom_range(0, 1) == 1;
      ardvld  = $urandom_range(0, 4) > 1;
      brdvld  = $urandom_range(0, 4) > 1;
      awrbe   = 4'($urandom_range(0, 15));
      bwrbe   = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
